// File: rtl/end_module.sv
// end_module: element-wise vector adder.
// Streams vector A then vector B on n, one word per clock, accumulates
// S[i] = A[i] + B[i] (modulo 2^WIDTH) in an N-entry storage array, then
// presents S[0..N-1] on s with ack high for exactly N consecutive cycles.
module end_module #(
    parameter int WIDTH = 8,
    parameter int N     = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] s,
    output logic             ack
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  mem_q [N];
    logic [WIDTH-1:0]  s_q, s_d;
    logic              ack_q, ack_d;

    // Storage write port, driven by the output/datapath decode.
    logic              wr_en_s;
    logic [WIDTH-1:0]  wr_data_s;
    logic              last_s;

    // The index is 0 on entry to every phase, so idx_q also addresses A[0] in IDLE.
    assign last_s = (idx_q == LAST_IDX);

    // State and index register: async reset returns the FSM to IDLE, index 0.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and index sequencing through IDLE -> LOAD_A -> LOAD_B -> OUT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A[0] is captured on this edge; a single-element vector skips LOAD_A.
                    if (last_s) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_LOAD_B;
                    end else begin
                        idx_d   = IDX_ONE;
                        state_d = ST_LOAD_A;
                    end
                end else begin
                    idx_d   = IDX_ZERO;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (last_s) begin
                    idx_d   = IDX_ZERO;
                    state_d = ST_LOAD_B;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (last_s) begin
                    idx_d   = IDX_ZERO;
                    state_d = ST_OUT;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_LOAD_B;
                end
            end
            ST_OUT: begin
                if (last_s) begin
                    idx_d   = IDX_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_OUT;
                end
            end
            default: begin
                idx_d   = IDX_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and storage decode: load A, accumulate B in place, stream sums out.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = n;
        s_d       = s_q;
        ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = n;
                end else begin
                    wr_en_s   = 1'b0;
                    wr_data_s = n;
                end
            end
            ST_LOAD_A: begin
                // Overwriting every entry here clears any residue from the last frame.
                wr_en_s   = 1'b1;
                wr_data_s = n;
            end
            ST_LOAD_B: begin
                // Plain WIDTH-bit add: the carry is intentionally dropped.
                wr_en_s   = 1'b1;
                wr_data_s = mem_q[idx_q] + n;
            end
            ST_OUT: begin
                s_d   = mem_q[idx_q];
                ack_d = 1'b1;
            end
            default: begin
                wr_en_s = 1'b0;
                s_d     = s_q;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Storage array: cleared by reset, written one entry per LOAD cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[idx_q] <= wr_data_s;
        end else begin
            mem_q[idx_q] <= mem_q[idx_q];
        end
    end

    // Registered result word and handshake; s holds its value outside OUT.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s_q   <= {WIDTH{1'b0}};
            ack_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            ack_q <= ack_d;
        end
    end

    assign s   = s_q;
    assign ack = ack_q;

endmodule

// File: tb/tb_end_module.sv
// Scoreboard bench for end_module: the driver pushes expected sums and the
// expected first-ack cycle per frame; a negedge monitor pops and compares.
module tb_end_module;

    localparam int WIDTH = 8;
    localparam int N     = 5;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             start;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] s;
    logic             ack;

    end_module #(.WIDTH(WIDTH), .N(N)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .n     (n),
        .s     (s),
        .ack   (ack)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int cycle_cnt = 0;
    int run_len = 0;
    logic ack_prev = 1'b0;
    int last_word = 0;

    int exp_q[$];
    int lat_q[$];

    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Monitor: compares every presented word and the timing of each ack pulse.
    always @(negedge Clk) begin
        if (ack === 1'b1) begin
            if (ack_prev !== 1'b1) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    $display("FAIL ack_rise: got ack=1 at cycle %0d, required no pending frame", cycle_cnt);
                end else begin
                    chk("ack_latency", cycle_cnt, lat_q.pop_front());
                end
            end
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL s_word: got s=%0d with ack=1, required no word pending", s);
            end else begin
                chk("s_word", int'(s), exp_q.pop_front());
            end
            run_len++;
        end else begin
            if (run_len != 0) begin
                chk("ack_pulse_len", run_len, N);
                run_len = 0;
            end
        end
        ack_prev = ack;
    end

    // One frame: E0..E(3N-1). abort_k >= 0 asserts Rst before edge E(abort_k).
    task automatic run_frame(input logic [WIDTH-1:0] a[N], input logic [WIDTH-1:0] b[N],
                             input bit tog, input int abort_k);
        for (int k = 0; k < 3 * N; k++) begin
            @(negedge Clk);
            if (k == abort_k) begin
                Rst = 1'b1;
                start = 1'b1;
                n = WIDTH'($urandom);
                #1;
                chk("abort_ack", int'(ack), 0);
                chk("abort_s", int'(s), 0);
                last_word = 0;
                @(negedge Clk);
                chk("abort_hold_ack", int'(ack), 0);
                Rst = 1'b0;
                start = 1'b0;
                break;
            end
            if (k == 0) begin
                start = 1'b1;
                if (abort_k < 0) begin
                    for (int i = 0; i < N; i++) begin
                        exp_q.push_back((int'(a[i]) + int'(b[i])) % (1 << WIDTH));
                    end
                    last_word = (int'(a[N-1]) + int'(b[N-1])) % (1 << WIDTH);
                    lat_q.push_back(cycle_cnt + 1 + 2 * N);
                end
            end else begin
                start = tog ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (k < N) n = a[k];
            else if (k < 2 * N) n = b[k - N];
            else n = WIDTH'($urandom);
        end
    endtask

    // Idle cycles: ack must drop after the last OUT word and s must hold.
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (i >= 1) begin
                chk("idle_ack", int'(ack), 0);
                chk("idle_s_hold", int'(s), last_word);
            end
            start = 1'b0;
            n = WIDTH'($urandom);
        end
    endtask

    logic [WIDTH-1:0] va[N];
    logic [WIDTH-1:0] vb[N];

    initial begin
        // Reset with activity on start/n: must be ignored.
        Rst = 1'b1;
        start = 1'b1;
        n = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n = WIDTH'($urandom);
            chk("reset_ack", int'(ack), 0);
            chk("reset_s", int'(s), 0);
        end
        Rst = 1'b0;
        start = 1'b0;

        // Idle hold with random n.
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("idle_hold_ack", int'(ack), 0);
            chk("idle_hold_s", int'(s), 0);
            n = WIDTH'($urandom);
        end

        // Basic frame.
        va = '{8'd2, 8'd5, 8'd10, 8'd0, 8'd2};
        vb = '{8'd8, 8'd9, 8'd1, 8'd4, 8'd2};
        run_frame(va, vb, 1'b0, -1);
        idle(3);

        // Wrap-around.
        va = '{8'd200, 8'd255, 8'd128, 8'd0, 8'd1};
        vb = '{8'd100, 8'd1, 8'd128, 8'd0, 8'd255};
        run_frame(va, vb, 1'b0, -1);
        idle(3);

        // Mid-frame reset during LOAD_B, then a fresh frame.
        for (int i = 0; i < N; i++) begin
            va[i] = WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
        end
        run_frame(va, vb, 1'b0, 7);
        idle(4);
        for (int i = 0; i < N; i++) begin
            va[i] = WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
        end
        run_frame(va, vb, 1'b0, -1);

        // Back-to-back: second start on the first IDLE edge.
        va = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        vb = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        run_frame(va, vb, 1'b0, -1);
        idle(3);

        // Random frames, alternating start toggling and random gaps.
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < N; i++) begin
                va[i] = WIDTH'($urandom);
                vb[i] = WIDTH'($urandom);
            end
            run_frame(va, vb, f[0], -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(2, 4)));
        end
        idle(3);

        // Drain: everything expected must have been delivered.
        begin
            int t;
            t = 0;
            while ((exp_q.size() != 0 || ack === 1'b1) && t < 100) begin
                @(negedge Clk);
                t++;
            end
        end
        @(negedge Clk);
        chk("drain_words_left", exp_q.size(), 0);
        chk("drain_frames_left", lat_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
